// File: rtl/rip_ro_counter_bank.sv
// rip_ro_counter_bank: gated ring-oscillator bank with windowed edge counters drained over valid/ready.
// Define RIP_RO_SATURATE_EN to make the channel counters saturate instead of wrap.
`timescale 1ns/1ps
module rip_ro_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int RO_SIZE = 3,
  parameter int INVERTER_DELAY = 1,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int SETTLE = 4,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [WIN_W-1:0]  window,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              busy,
  output logic              count_valid,
  input  logic              count_ready,
  output logic [CH_W-1:0]   count_ch,
  output logic [CNT_W-1:0]  count_data,
  output logic              count_last,
  output logic              overflow
);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2, DRAIN = 2'd3;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  logic [1:0] state;
  logic [WIN_W-1:0] win_q, timer;
  logic [NUM_CH-1:0] run, rise;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CH_W-1:0] idx;
  logic hs;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    (* ALLOW_COMBINATORIAL_LOOPS = "true", KEEP = "true", DONT_TOUCH = "true" *) logic ring [RO_SIZE];
    logic ro_out;
    logic [2:0] sync;
    // The gating stage forces an odd-length chain low, so a stopped ring rests with ro_out=0.
    assign #(INVERTER_DELAY) ring[0] = run[i] & rstn & ~ring[RO_SIZE-1];
    for (genvar j = 1; j < RO_SIZE; j++) begin : g_inv
      assign #(INVERTER_DELAY) ring[j] = ~ring[j-1];
    end
    assign ro_out = ring[RO_SIZE-1];
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) sync <= '0;
      else sync <= {sync[1:0], ro_out};
    assign rise[i] = sync[1] & ~sync[2];
  end
  assign busy = state != IDLE;
  assign count_valid = state == DRAIN;
  assign count_ch = idx;
  assign count_data = count_valid ? cnt[idx] : '0;
  assign count_last = count_valid && idx == LAST_CH;
  assign hs = count_valid && count_ready;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      win_q <= '0;
      timer <= '0;
      run <= '0;
      idx <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          win_q <= window;
          run <= ch_en;
          timer <= '0;
          overflow <= 1'b0;
          for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
          state <= ARM;
        end
        ARM: begin
          timer <= timer + 1'b1;
          if (timer == WIN_W'(SETTLE - 1)) begin
            timer <= '0;
            state <= (win_q == '0) ? DRAIN : MEASURE;
            if (win_q == '0) run <= '0;
          end
        end
        MEASURE: begin
          timer <= timer + 1'b1;
          for (int k = 0; k < NUM_CH; k++)
            if (rise[k]) begin
              if (&cnt[k]) overflow <= 1'b1;
`ifdef RIP_RO_SATURATE_EN
              if (!(&cnt[k])) cnt[k] <= cnt[k] + 1'b1;
`else
              cnt[k] <= cnt[k] + 1'b1;
`endif
            end
          if (timer == win_q - 1'b1) begin
            run <= '0;
            state <= DRAIN;
          end
        end
        default: if (hs) begin
          idx <= (idx == LAST_CH) ? '0 : idx + 1'b1;
          if (idx == LAST_CH) state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_rip_ro_counter_bank.sv
// tb_rip_ro_counter_bank: vector table plus scoreboard for the ring-oscillator counter bank.
`timescale 1ns/1ps
module tb_rip_ro_counter_bank;
  logic clk = 0, rstn = 0, start = 0, count_ready = 0;
  logic [15:0] window = '0;
  logic [3:0] ch_en = '0;
  logic busy, count_valid, count_last, overflow;
  logic [1:0] count_ch;
  logic [15:0] count_data;
  logic busy4, valid4, last4, ovf4;
  logic [1:0] ch4;
  logic [3:0] data4;
  int errors = 0, checks = 0;
  typedef struct { int ch; int lo; int hi; } exp_t;
  typedef struct { logic [3:0] en; logic [15:0] win; int lo; int hi; int bp; int poke; } vec_t;
  exp_t sb[$];
  vec_t vecs[5];
  always #5 clk = ~clk;
  rip_ro_counter_bank #(.NUM_CH(4), .RO_SIZE(5), .INVERTER_DELAY(5), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .window(window), .ch_en(ch_en), .busy(busy),
    .count_valid(count_valid), .count_ready(count_ready), .count_ch(count_ch),
    .count_data(count_data), .count_last(count_last), .overflow(overflow));
  rip_ro_counter_bank #(.NUM_CH(4), .RO_SIZE(5), .INVERTER_DELAY(5), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .window(window), .ch_en(ch_en), .busy(busy4),
    .count_valid(valid4), .count_ready(count_ready), .count_ch(ch4),
    .count_data(data4), .count_last(last4), .overflow(ovf4));
  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic launch(input logic [3:0] en, input logic [15:0] win, input int lo, input int hi);
    exp_t e;
    @(negedge clk);
    window = win;
    ch_en = en;
    start = 1;
    for (int i = 0; i < 4; i++) begin
      e.ch = i;
      e.lo = (en[i] && win != 0) ? lo : 0;
      e.hi = (en[i] && win != 0) ? hi : 0;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1, 1);
  endtask
  task automatic drain(input int bp, input int poke, input bit ovf_chk);
    int cyc = 0, got = 0, vcyc = 0;
    bit pstall = 0, ok;
    logic [1:0] pch = '0;
    logic [15:0] pdata = '0;
    exp_t e;
    while (got < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (pstall) begin
        chk("stall_valid", count_valid, 1, 1);
        chk("stall_ch", count_ch, pch, pch);
        chk("stall_data", count_data, pdata, pdata);
      end
      if (count_valid) vcyc++;
      count_ready = (bp == 0) || (vcyc > 7 && vcyc % 2 == 1);
      if (count_valid && count_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0, 0);
        else begin
          e = sb.pop_front();
          chk("count_ch", count_ch, e.ch, e.ch);
          chk("count_data", count_data, e.lo, e.hi);
          chk("count_last", count_last, e.ch == 3, e.ch == 3);
          if (ovf_chk) begin
`ifdef RIP_RO_SATURATE_EN
            chk("sat_data4", data4, 15, 15);
`else
            ok = 0;
            for (int v = e.lo; v <= e.hi; v++) if (int'(data4) == v % 16) ok = 1;
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL wrap_data4: got %0d want (%0d..%0d) mod 16", data4, e.lo, e.hi);
            end
`endif
          end
        end
        got++;
        if ((poke == 1 && got == 1) || (poke == 2 && got == 4)) begin
          start = 1;
          window = 16'd100;
          ch_en = 4'hf;
        end
      end
      pstall = count_valid && !count_ready;
      pch = count_ch;
      pdata = count_data;
    end
    if (got < 4) chk("drain_timeout", got, 4, 4);
    @(negedge clk);
    start = 0;
    count_ready = 1;
    chk("busy_done", busy, 0, 0);
    chk("valid_done", count_valid, 0, 0);
    if (poke != 0) begin
      repeat (10) @(negedge clk);
      chk("start_ignored", busy, 0, 0);
    end
  endtask
  initial begin
    vecs[0] = '{4'hf, 16'd100, 19, 21, 0, 0};
    vecs[1] = '{4'h5, 16'd100, 19, 21, 0, 0};
    vecs[2] = '{4'hf, 16'd100, 19, 21, 1, 0};
    vecs[3] = '{4'hf, 16'd0, 0, 0, 0, 1};
    vecs[4] = '{4'ha, 16'd60, 11, 13, 0, 2};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0, 0);
    chk("rst_valid", count_valid, 0, 0);
    chk("rst_ch", count_ch, 0, 0);
    chk("rst_data", count_data, 0, 0);
    chk("rst_last", count_last, 0, 0);
    chk("rst_overflow", overflow, 0, 0);
    rstn = 1;
    count_ready = 1;
    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].en, vecs[i].win, vecs[i].lo, vecs[i].hi);
      drain(vecs[i].bp, vecs[i].poke, 0);
      chk("overflow_clear", overflow, 0, 0);
    end
    launch(4'hf, 16'd400, 79, 81);
    drain(0, 0, 1);
    chk("overflow16", overflow, 0, 0);
    chk("overflow4", ovf4, 1, 1);
    launch(4'hf, 16'd100, 19, 21);
    repeat (54) @(negedge clk);
    rstn = 0;
    #1;
    chk("mid_rst_busy", busy, 0, 0);
    chk("mid_rst_valid", count_valid, 0, 0);
    chk("mid_rst_overflow4", ovf4, 0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("ring0_stopped", dut.g_ch[0].ro_out, 0, 0);
      chk("ring3_stopped", dut.g_ch[3].ro_out, 0, 0);
      @(negedge clk);
    end
    sb.delete();
    rstn = 1;
    launch(4'hf, 16'd100, 19, 21);
    drain(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
